// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction fetch stage with PC register and IF/ID pipeline reg.
//
// The PC drives a combinational instruction ROM directly, so an instruction
// reaches the decode stage one cycle after its address is presented. The next
// PC is chosen by priority: reset, taken branch, jump, stall hold, PC+1.
// A redirect (branch or jump) always flushes IF/ID to a NOP bubble and wins
// over a concurrent stall.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous, active-high reset
//   stall          in   hazard hold; freezes PC and IF/ID
//   branch_taken   in   resolved taken branch from execute
//   branch_target  in   [AW]  branch word address
//   jump           in   decoded jump from decode
//   jump_target    in   [AW]  jump word address
//   inst_addr      out  [AW]  current PC to the instruction ROM
//   inst_in        in   [32]  ROM data for inst_addr
//   if_id_inst     out  [32]  registered instruction
//   if_id_pc       out  [AW]  address of if_id_inst
//   if_id_npc      out  [AW]  if_id_pc + 1 (wraps)
//   if_id_valid    out        1 = real instruction, 0 = bubble
//   redirect_cnt   out  [8]   saturating count of taken redirects
// -----------------------------------------------------------------------------
module if_stage #(
  parameter int              AW       = 6,
  parameter logic [AW-1:0]   RESET_PC = 6'h00,
  parameter logic [31:0]     NOP      = 32'h00000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  input  logic          jump,
  input  logic [AW-1:0] jump_target,
  output logic [AW-1:0] inst_addr,
  input  logic [31:0]   inst_in,
  output logic [31:0]   if_id_inst,
  output logic [AW-1:0] if_id_pc,
  output logic [AW-1:0] if_id_npc,
  output logic          if_id_valid,
  output logic [7:0]    redirect_cnt
);

  logic [AW-1:0] pc;
  logic [AW-1:0] pc_seq;
  logic [AW-1:0] pc_next;
  logic          redirect;

  assign inst_addr = pc;
  assign redirect  = branch_taken | jump;
  // Natural AW-bit overflow gives the 3F -> 00 wrap.
  assign pc_seq    = pc + AW'(1);

  // Targets are only looked at while their own qualifier is high, so an
  // undriven target on an idle cycle never reaches the PC.
  always_comb begin
    pc_next = pc_seq;
    if (branch_taken)
      pc_next = branch_target;
    else if (jump)
      pc_next = jump_target;
    else if (stall)
      pc_next = pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc <= RESET_PC;
    else
      pc <= pc_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_inst  <= NOP;
      if_id_pc    <= '0;
      if_id_npc   <= '0;
      if_id_valid <= 1'b0;
    end else if (redirect) begin
      if_id_inst  <= NOP;
      if_id_pc    <= '0;
      if_id_npc   <= '0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      if_id_inst  <= inst_in;
      if_id_pc    <= pc;
      if_id_npc   <= pc_seq;
      if_id_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      redirect_cnt <= 8'h00;
    else if (redirect && (redirect_cnt != 8'hFF))
      redirect_cnt <= redirect_cnt + 8'd1;
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [5:0]  branch_target;
  logic        jump;
  logic [5:0]  jump_target;
  logic [5:0]  inst_addr;
  logic [31:0] inst_in;
  logic [31:0] if_id_inst;
  logic [5:0]  if_id_pc;
  logic [5:0]  if_id_npc;
  logic        if_id_valid;
  logic [7:0]  redirect_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] rom [64];

  always #5 clk = ~clk;

  assign inst_in = rom[inst_addr];

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .inst_addr     (inst_addr),
    .inst_in       (inst_in),
    .if_id_inst    (if_id_inst),
    .if_id_pc      (if_id_pc),
    .if_id_npc     (if_id_npc),
    .if_id_valid   (if_id_valid),
    .redirect_cnt  (redirect_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a fetch-stream view. The PC walks the word space modulo
  // 64; any redirect replaces it and turns the decode slot into a bubble.
  int          m_pc    = 0;
  logic [31:0] m_inst  = 32'h0;
  int          m_ipc   = 0;
  int          m_npc   = 0;
  logic        m_valid = 1'b0;
  int          m_cnt   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= 0; m_inst <= 32'h0; m_ipc <= 0; m_npc <= 0; m_valid <= 1'b0; m_cnt <= 0;
    end else if (branch_taken || jump) begin
      m_pc    <= branch_taken ? int'(branch_target) : int'(jump_target);
      m_inst  <= 32'h0; m_ipc <= 0; m_npc <= 0; m_valid <= 1'b0;
      m_cnt   <= (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
    end else if (!stall) begin
      m_inst  <= rom[m_pc];
      m_ipc   <= m_pc;
      m_npc   <= (m_pc + 1) % 64;
      m_valid <= 1'b1;
      m_pc    <= (m_pc + 1) % 64;
    end
  end

  always @(negedge clk) begin
    chk("m_addr",  32'(inst_addr),    32'(m_pc));
    chk("m_inst",  if_id_inst,        m_inst);
    chk("m_pc",    32'(if_id_pc),     32'(m_ipc));
    chk("m_npc",   32'(if_id_npc),    32'(m_npc));
    chk("m_valid", 32'(if_id_valid),  32'(m_valid));
    chk("m_cnt",   32'(redirect_cnt), 32'(m_cnt));
  end

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hC0DE_0000 + 32'(i) * 32'h0000_0111;
    stall = 1'b0; branch_taken = 1'b0; branch_target = 6'h00;
    jump = 1'b0; jump_target = 6'h00;
    rst = 1'b0;
    #1 rst = 1'b1;

    // reset values
    @(negedge clk);
    chk("rst_addr",  32'(inst_addr),    32'h00);
    chk("rst_inst",  if_id_inst,        32'h0);
    chk("rst_valid", 32'(if_id_valid),  32'h0);
    chk("rst_cnt",   32'(redirect_cnt), 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;

    // sequential fetch
    for (int i = 0; i < 4; i++) begin
      edge_step();
      chk("seq_addr",  32'(inst_addr),   32'(i + 1));
      chk("seq_pc",    32'(if_id_pc),    32'(i));
      chk("seq_npc",   32'(if_id_npc),   32'(i + 1));
      chk("seq_valid", 32'(if_id_valid), 32'h1);
      chk("seq_inst",  if_id_inst,       32'hC0DE_0000 + 32'(i) * 32'h111);
    end
    repeat (4) edge_step();
    chk("pre_br_addr", 32'(inst_addr), 32'h08);

    // taken branch from 08 to 0A
    branch_taken = 1'b1; branch_target = 6'h0A;
    edge_step();
    branch_taken = 1'b0;
    chk("br_addr",  32'(inst_addr),    32'h0A);
    chk("br_inst",  if_id_inst,        32'h0);
    chk("br_valid", 32'(if_id_valid),  32'h0);
    chk("br_cnt",   32'(redirect_cnt), 32'h1);
    edge_step();
    chk("br_next_pc",    32'(if_id_pc),    32'h0A);
    chk("br_next_valid", 32'(if_id_valid), 32'h1);

    // branch + jump + stall on one edge
    branch_taken = 1'b1; branch_target = 6'h0A;
    jump = 1'b1; jump_target = 6'h01; stall = 1'b1;
    edge_step();
    branch_taken = 1'b0; jump = 1'b0; stall = 1'b0;
    chk("col_addr",  32'(inst_addr),    32'h0A);
    chk("col_valid", 32'(if_id_valid),  32'h0);
    chk("col_pc",    32'(if_id_pc),     32'h00);
    chk("col_cnt",   32'(redirect_cnt), 32'h2);

    // stall hold at PC 05
    jump = 1'b1; jump_target = 6'h04;
    edge_step();
    jump = 1'b0;
    edge_step();
    chk("st_pre_addr", 32'(inst_addr), 32'h05);
    chk("st_pre_pc",   32'(if_id_pc),  32'h04);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge_step();
      chk("st_addr",  32'(inst_addr),   32'h05);
      chk("st_pc",    32'(if_id_pc),    32'h04);
      chk("st_npc",   32'(if_id_npc),   32'h05);
      chk("st_valid", 32'(if_id_valid), 32'h1);
    end
    stall = 1'b0;
    edge_step();
    chk("st_rel_pc",   32'(if_id_pc),     32'h05);
    chk("st_rel_addr", 32'(inst_addr),    32'h06);
    chk("st_rel_cnt",  32'(redirect_cnt), 32'h3);

    // redirect to the current PC still flushes
    jump = 1'b1; jump_target = 6'h06;
    edge_step();
    jump = 1'b0;
    chk("self_addr",  32'(inst_addr),    32'h06);
    chk("self_valid", 32'(if_id_valid),  32'h0);
    chk("self_cnt",   32'(redirect_cnt), 32'h4);

    // wrap 3F -> 00
    jump = 1'b1; jump_target = 6'h3F;
    edge_step();
    jump = 1'b0;
    edge_step();
    chk("wrap_addr", 32'(inst_addr), 32'h00);
    chk("wrap_pc",   32'(if_id_pc),  32'h3F);
    chk("wrap_npc",  32'(if_id_npc), 32'h00);

    // counter saturation: 300 back-to-back jumps, starting from 5
    jump = 1'b1;
    for (int k = 0; k < 300; k++) begin
      jump_target = 6'(k % 64);
      edge_step();
      if (k == 199) chk("sat_mid", 32'(redirect_cnt), 32'd205);
    end
    jump = 1'b0;
    chk("sat_cnt", 32'(redirect_cnt), 32'hFF);
    edge_step();
    chk("sat_hold", 32'(redirect_cnt), 32'hFF);

    // asynchronous reset between edges while PC = 12
    jump = 1'b1; jump_target = 6'h12;
    edge_step();
    jump = 1'b0;
    chk("ar_pre_addr", 32'(inst_addr), 32'h12);
    stall = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("ar_addr",  32'(inst_addr),    32'h00);
    chk("ar_valid", 32'(if_id_valid),  32'h0);
    chk("ar_cnt",   32'(redirect_cnt), 32'h0);
    chk("ar_inst",  if_id_inst,        32'h0);
    @(posedge clk);
    #2 rst = 1'b0; stall = 1'b0;
    edge_step();
    chk("ar_first_pc",    32'(if_id_pc),    32'h00);
    chk("ar_first_valid", 32'(if_id_valid), 32'h1);
    chk("ar_first_addr",  32'(inst_addr),   32'h01);

    repeat (2) edge_step();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
